// File: rtl/jk_seq_pkg.sv
// Shared types, the fixed J/K program and the JK next-state function used by the
// stimulus sequencer, its golden model and the benches.
package jk_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    DRIVE,
    FINISH
  } seq_state_e;

  localparam int NUM_STEPS = 6;

  // Each entry is {J, K}: set, reset, toggle, toggle, hold, set
  localparam logic [1:0] PROGRAM [NUM_STEPS] = '{2'b10, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10};

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    case ({j, k})
      2'b00:   return q;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~q;
    endcase
  endfunction

endpackage

// File: rtl/jk_stimulus_sequencer_if.sv
// Connection between the stimulus sequencer (master) and the flip-flop under test (slave).
interface jk_stimulus_sequencer_if;
  logic j_out;
  logic k_out;
  logic ff_rst;
  logic q_in;

  modport master (output j_out, output k_out, output ff_rst, input q_in);
  modport slave  (input j_out, input k_out, input ff_rst, output q_in);
endinterface

// File: rtl/jk_golden_model.sv
// Reference Q for a JK flip-flop: follows the same registered J/K the device samples,
// held at 0 while the device is in reset.
module jk_golden_model
  import jk_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic j,
  input  logic k,
  output logic exp_q
);

  logic exp_d;

  always_comb begin
    exp_d = jk_next(exp_q, j, k);
    if (clr) begin
      exp_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q <= 1'b0;
    end else begin
      exp_q <= exp_d;
    end
  end

endmodule

// File: rtl/jk_stimulus_sequencer.sv
// Walks the 6-step J/K program into the lab flip-flop and counts Q mismatches against a golden model.
// Build option: define JK_SEQ_LOOP_EN to restart runs back-to-back after the first start.
module jk_stimulus_sequencer
  import jk_seq_pkg::*;
#(
  parameter int STEP_CYCLES = 4,
  parameter int ERR_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  jk_stimulus_sequencer_if.master ff,
  output logic [2:0]           step_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count
);

  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  seq_state_e       state_q, state_d;
  logic             j_q, j_d, k_q, k_d, ff_rst_q, ff_rst_d;
  logic [2:0]       step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d, err_run;
  logic             exp_q;
  logic             checking;

  jk_golden_model u_golden (
    .clk   (clk),
    .rst   (rst),
    .clr   (ff_rst_q),
    .j     (j_q),
    .k     (k_q),
    .exp_q (exp_q)
  );

  assign checking = (state_q == DRIVE) || (state_q == FINISH);

  always_comb begin
    err_run = err_q;
    if (checking && (ff.q_in != exp_q) && (err_q != ERR_MAX)) begin
      err_run = err_q + ERR_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    j_d      = j_q;
    k_d      = k_q;
    ff_rst_d = ff_rst_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        ff_rst_d = 1'b1;
        j_d      = 1'b0;
        k_d      = 1'b0;
        if (start) begin
          state_d = INIT;
          busy_d  = 1'b1;
          err_d   = '0;
          pass_d  = 1'b0;
        end
      end
      INIT: begin
        state_d    = DRIVE;
        step_d     = 3'd0;
        cnt_d      = '0;
        ff_rst_d   = 1'b0;
        {j_d, k_d} = PROGRAM[0];
      end
      DRIVE: begin
        err_d = err_run;
        if (cnt_q == CNT_W'(STEP_CYCLES - 1)) begin
          cnt_d = '0;
          if (step_q == 3'(NUM_STEPS - 1)) begin
            state_d  = FINISH;
            j_d      = 1'b0;
            k_d      = 1'b0;
            ff_rst_d = 1'b1;
          end else begin
            step_d     = step_q + 3'd1;
            {j_d, k_d} = PROGRAM[step_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FINISH: begin
        done_d = 1'b1;
        pass_d = (err_run == '0);
`ifdef JK_SEQ_LOOP_EN
        // Soak mode: the verdict above is taken before the counter is cleared for the next run
        state_d = INIT;
        busy_d  = 1'b1;
        err_d   = '0;
`else
        state_d = IDLE;
        busy_d  = 1'b0;
        err_d   = err_run;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      j_q      <= 1'b0;
      k_q      <= 1'b0;
      ff_rst_q <= 1'b1;
      step_q   <= 3'd0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      j_q      <= j_d;
      k_q      <= k_d;
      ff_rst_q <= ff_rst_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
    end
  end

  assign ff.j_out  = j_q;
  assign ff.k_out  = k_q;
  assign ff.ff_rst = ff_rst_q;
  assign step_idx  = step_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

endmodule
